// File: rtl/job_launcher.sv
// rtl/job_launcher.sv - queues job IDs, launches them on the go/finish timer under a watchdog, reports completions
module job_launcher #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 20,
    parameter int CLR_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [ID_W-1:0] req_id,
    output logic            req_ready,
    output logic            go,
    output logic            tmr_rst_n,
    input  logic            finish,
    input  logic [1:0]      tmr_state,
    output logic            done_valid,
    output logic [ID_W-1:0] done_id,
    output logic            done_err,
    input  logic            done_ready,
    output logic [7:0]      jobs_ok,
    output logic [7:0]      jobs_err,
    output logic            busy
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WW  = $clog2(TIMEOUT + 1);
    localparam int CCW = $clog2(CLR_CYC + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, REPORT, CLEAR} state_t;

    state_t          state, state_d;
    logic [ID_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [ID_W-1:0] cur_id;
    logic [WW-1:0]   wcnt;
    logic [CCW-1:0]  ccnt;
    logic            full, empty, push, pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == LAUNCH);
    assign busy      = (state != IDLE) || !empty;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!empty && tmr_state == 2'b00 && tmr_rst_n) state_d = LAUNCH;
            LAUNCH:  state_d = RUN;
            RUN:     if (finish || wcnt == WW'(TIMEOUT - 1)) state_d = REPORT;
            REPORT:  if (done_ready) state_d = CLEAR;
            CLEAR:   if (ccnt == CCW'(CLR_CYC - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Storage needs no reset; occupancy is governed by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Outputs are registered from the next state so each is high exactly while in its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            go         <= 1'b0;
            tmr_rst_n  <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_err   <= 1'b0;
            jobs_ok    <= '0;
            jobs_err   <= '0;
            cur_id     <= '0;
            wcnt       <= '0;
            ccnt       <= '0;
        end else begin
            state      <= state_d;
            go         <= (state_d == LAUNCH);
            tmr_rst_n  <= (state_d != CLEAR);
            done_valid <= (state_d == REPORT);
            case (state)
                LAUNCH: begin
                    cur_id <= mem[rd_ptr];
                    wcnt   <= '0;
                end
                RUN: begin
                    if (state_d == REPORT) begin
                        done_id  <= cur_id;
                        done_err <= !finish;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (done_ready) begin
                        if (done_err) jobs_err <= jobs_err + 8'd1;
                        else          jobs_ok  <= jobs_ok + 8'd1;
                        ccnt <= '0;
                    end
                end
                CLEAR:   ccnt <= ccnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_job_launcher.sv
// tb/tb_job_launcher.sv - scoreboard bench for job_launcher with a 15-cycle timer model
module tb_job_launcher;
    localparam int ID_W    = 4;
    localparam int TIMEOUT = 20;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic [ID_W-1:0] req_id;
    logic            req_ready;
    logic            go;
    logic            tmr_rst_n;
    logic            finish;
    logic [1:0]      tmr_state;
    logic            done_valid;
    logic [ID_W-1:0] done_id;
    logic            done_err;
    logic            done_ready;
    logic [7:0]      jobs_ok;
    logic [7:0]      jobs_err;
    logic            busy;

    job_launcher #(.DEPTH(4), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .CLR_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready),
        .go(go), .tmr_rst_n(tmr_rst_n), .finish(finish), .tmr_state(tmr_state),
        .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .done_ready(done_ready),
        .jobs_ok(jobs_ok), .jobs_err(jobs_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Timer model: go at cycle t -> DONE (finish) from t+15, held until tmr_rst_n.
    logic [3:0] tcnt;
    logic       finish_en;
    always @(posedge clk or negedge tmr_rst_n) begin
        if (!tmr_rst_n) begin
            tmr_state <= 2'b00;
            tcnt      <= 4'd0;
        end else begin
            case (tmr_state)
                2'b00: if (go) begin tmr_state <= 2'b01; tcnt <= 4'd0; end
                2'b01: if (tcnt == 4'd13) tmr_state <= 2'b11; else tcnt <= tcnt + 4'd1;
                default: ;
            endcase
        end
    end
    assign finish = (tmr_state == 2'b11) && finish_en;

    typedef struct { logic [ID_W-1:0] id; logic err; } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait expired (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold/latency rules.
    logic            prev_dv, prev_dr, prev_go, prev_err;
    logic [ID_W-1:0] prev_id;
    int              go_cyc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dv = 1'b0; prev_dr = 1'b0; prev_go = 1'b0;
        end else begin
            if (go) begin
                chk("go_single_cycle", prev_go, 0);
                chk("go_during_report", done_valid, 0);
                go_cyc = cyc;
            end
            if (done_valid && !prev_dv && exp_q.size() > 0)
                chk("done_latency", cyc - go_cyc, exp_q[0].err ? TIMEOUT + 1 : 16);
            if (prev_dv && !prev_dr) begin
                chk("done_valid_hold", done_valid, 1);
                chk("done_id_hold", done_id, prev_id);
                chk("done_err_hold", done_err, prev_err);
            end
            if (done_valid && done_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_completion");
                end else begin
                    chk("done_id", done_id, exp_q[0].id);
                    chk("done_err", done_err, exp_q[0].err);
                    void'(exp_q.pop_front());
                end
            end
            prev_dv = done_valid; prev_dr = done_ready; prev_go = go;
            prev_id = done_id; prev_err = done_err;
        end
    end

    task automatic push(input int id, input logic err);
        int k = 0;
        req_valid = 1'b1;
        req_id    = ID_W'(id);
        while (!req_ready && k < 400) begin @(posedge clk); #1; k++; end
        if (!req_ready) timeout_fail("push_accept");
        else begin
            exp_q.push_back('{id: ID_W'(id), err: err});
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin @(posedge clk); #1; k++; end
        if (busy) timeout_fail("wait_idle");
    endtask

    task automatic wait_hs();
        int k = 0;
        do begin @(negedge clk); k++; end while (!(done_valid && done_ready) && k < 200);
        if (!(done_valid && done_ready)) timeout_fail("wait_handshake");
    endtask

    task automatic wait_dv();
        int k = 0;
        while (!done_valid && k < 200) begin @(posedge clk); #1; k++; end
        if (!done_valid) timeout_fail("wait_done_valid");
    endtask

    task automatic wait_go();
        int k = 0;
        while (!go && k < 200) begin @(posedge clk); #1; k++; end
        if (!go) timeout_fail("wait_go");
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_id = '0; done_ready = 1'b1; finish_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_go", go, 0);
        chk("rst_tmr_rst_n", tmr_rst_n, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_jobs_ok", jobs_ok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tmr_rst_n_release", tmr_rst_n, 1);

        // Single job, consumer ready.
        push(3, 1'b0);
        req_valid = 1'b0;
        wait_hs();
        @(negedge clk); chk("clear_cycle1", tmr_rst_n, 0);
        @(negedge clk); chk("clear_cycle2", tmr_rst_n, 0);
        @(negedge clk); chk("clear_exit", tmr_rst_n, 1);
        chk("jobs_ok_1", jobs_ok, 1);
        wait_idle(100);

        // Fill past depth with stalled consumer, then hold REPORT for 10 cycles.
        done_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(i, 1'b0);
        chk("full_req_ready", req_ready, 0);
        req_valid = 1'b0;
        wait_dv();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_done_valid", done_valid, 1);
            chk("stall_done_id", done_id, 1);
            chk("stall_no_go", go, 0);
            chk("stall_no_clear", tmr_rst_n, 1);
        end
        done_ready = 1'b1;
        wait_idle(600);

        // Watchdog timeout, then a queued job still runs.
        finish_en = 1'b0;
        push(7, 1'b1);
        push(9, 1'b0);
        req_valid = 1'b0;
        wait_hs();
        finish_en = 1'b1;
        @(negedge clk);
        chk("jobs_err_1", jobs_err, 1);
        chk("timeout_restart", tmr_rst_n, 0);
        wait_idle(100);
        chk("jobs_ok_7", jobs_ok, 7);

        // Reset in RUN with two IDs queued.
        push(5, 1'b0);
        push(6, 1'b0);
        push(8, 1'b0);
        req_valid = 1'b0;
        wait_go();
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_go", go, 0);
        chk("midrst_tmr_rst_n", tmr_rst_n, 0);
        chk("midrst_done_valid", done_valid, 0);
        chk("midrst_jobs_ok", jobs_ok, 0);
        chk("midrst_jobs_err", jobs_err, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_jobs_ok", jobs_ok, 0);

        // Push coinciding with pop at occupancy 2.
        done_ready = 1'b0;
        push(10, 1'b0);
        push(11, 1'b0);
        push(12, 1'b0);
        req_valid = 1'b0;
        wait_dv();
        done_ready = 1'b1;
        wait_go();
        push(13, 1'b0);
        chk("occ2_after_push_pop", req_ready, 1);
        push(14, 1'b0);
        chk("occ3_ready", req_ready, 1);
        push(15, 1'b0);
        chk("occ4_full", req_ready, 0);
        req_valid = 1'b0;
        wait_idle(800);
        chk("jobs_ok_6", jobs_ok, 6);

        // Counter wrap: 249 more to reach 255, then one more wraps to 0.
        for (int i = 0; i < 249; i++) push(i % 16, 1'b0);
        req_valid = 1'b0;
        wait_idle(800);
        chk("jobs_ok_255", jobs_ok, 255);
        push(1, 1'b0);
        req_valid = 1'b0;
        wait_idle(100);
        chk("jobs_ok_wrap", jobs_ok, 0);
        chk("jobs_err_wrap", jobs_err, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
